// File: rtl/sqrt2_host_if.sv
// sqrt2_host_if: upstream sequencer for the sqrt2 half-precision square-root core.
// Takes one operand per operation from a valid/ready stream, loads it onto the
// shared IO_DATA bus for a single cycle, waits for RESULT, captures the result
// word and flags, and presents them on a valid/ready output stream. ENABLE is
// kept low for at least GAP_CYCLES between operations so the core re-arms.
// Optional build macro SQRT2_HOST_IF_TIMEOUT_EN adds a WAIT watchdog that
// aborts after TIMEOUT_CYCLES with a quiet-NaN result and OUT_TIMEOUT set.
module sqrt2_host_if #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int GAP_CYCLES     = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [15:0] IN_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [15:0] OUT_DATA,
    output logic        OUT_NAN,
    output logic        OUT_PINF,
    output logic        OUT_NINF,
    output logic        OUT_TIMEOUT,
    output logic        BUSY,
    output logic        ENABLE,
    inout  wire  [15:0] IO_DATA,
    input  logic        RESULT,
    input  logic        IS_NAN,
    input  logic        IS_PINF,
    input  logic        IS_NINF
);

    // Parameter sanity checks at elaboration.
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("sqrt2_host_if: GAP_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("sqrt2_host_if: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] op_q, op_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_nan_q, out_nan_d;
    logic        out_pinf_q, out_pinf_d;
    logic        out_ninf_q, out_ninf_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic        gap_done;
    logic        timeout_hit;
    logic        bus_drive;

    // gap_cnt_q counts ENABLE-low cycles already completed since HOLD entry;
    // the current cycle makes it one more.
    assign gap_done = ({1'b0, gap_cnt_q} + 17'd1) >= 17'(GAP_CYCLES);

`ifdef SQRT2_HOST_IF_TIMEOUT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        out_timeout_q, out_timeout_d;

    assign timeout_hit = ({1'b0, wait_cnt_q} + 17'd1) >= 17'(TIMEOUT_CYCLES);
    assign OUT_TIMEOUT = out_timeout_q;

    // Watchdog: cleared in LOAD, counts WAIT cycles; flag updates on capture/abort.
    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        out_timeout_d = out_timeout_q;
        if (state_q == S_LOAD) begin
            wait_cnt_d = 16'd0;
        end else if (state_q == S_WAIT) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
            if (RESULT) begin
                out_timeout_d = 1'b0;
            end else if (timeout_hit) begin
                out_timeout_d = 1'b1;
            end
        end
    end

    // Watchdog registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt_q    <= 16'd0;
            out_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            out_timeout_q <= out_timeout_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign OUT_TIMEOUT = 1'b0;
`endif

    // FSM state register; async reset drops ENABLE and releases the bus at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; RESULT has priority over a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (IN_VALID) state_d = S_LOAD;
            S_LOAD: state_d = S_WAIT;
            S_WAIT: if (RESULT || timeout_hit) state_d = S_HOLD;
            S_HOLD: if (OUT_READY) state_d = gap_done ? S_IDLE : S_GAP;
            S_GAP:  if (gap_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs, decoded from state only.
    always_comb begin
        ENABLE    = (state_q == S_LOAD) || (state_q == S_WAIT);
        bus_drive = (state_q == S_LOAD);
        IN_READY  = (state_q == S_IDLE) && RST_N;
        BUSY      = (state_q != S_IDLE);
    end

    // Operand is on the bus for the LOAD cycle only; released otherwise.
    assign IO_DATA = bus_drive ? op_q : 16'hzzzz;

    // Datapath: operand latch, result capture, output handshake, gap counter.
    always_comb begin
        op_d        = op_q;
        out_data_d  = out_data_q;
        out_nan_d   = out_nan_q;
        out_pinf_d  = out_pinf_q;
        out_ninf_d  = out_ninf_q;
        out_valid_d = out_valid_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (IN_VALID) op_d = IN_DATA;
            end
            S_WAIT: begin
                if (RESULT) begin
                    out_data_d  = IO_DATA;
                    out_nan_d   = IS_NAN;
                    out_pinf_d  = IS_PINF;
                    out_ninf_d  = IS_NINF;
                    out_valid_d = 1'b1;
                    gap_cnt_d   = 16'd0;
                end else if (timeout_hit) begin
                    out_data_d  = 16'h7E00;
                    out_nan_d   = 1'b1;
                    out_pinf_d  = 1'b0;
                    out_ninf_d  = 1'b0;
                    out_valid_d = 1'b1;
                    gap_cnt_d   = 16'd0;
                end
            end
            S_HOLD: begin
                if (OUT_READY) out_valid_d = 1'b0;
                if (!gap_done) gap_cnt_d = gap_cnt_q + 16'd1;
            end
            S_GAP: begin
                if (!gap_done) gap_cnt_d = gap_cnt_q + 16'd1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_q        <= 16'd0;
            out_data_q  <= 16'd0;
            out_nan_q   <= 1'b0;
            out_pinf_q  <= 1'b0;
            out_ninf_q  <= 1'b0;
            out_valid_q <= 1'b0;
            gap_cnt_q   <= 16'd0;
        end else begin
            op_q        <= op_d;
            out_data_q  <= out_data_d;
            out_nan_q   <= out_nan_d;
            out_pinf_q  <= out_pinf_d;
            out_ninf_q  <= out_ninf_d;
            out_valid_q <= out_valid_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_NAN   = out_nan_q;
    assign OUT_PINF  = out_pinf_q;
    assign OUT_NINF  = out_ninf_q;

endmodule

// File: tb/tb_sqrt2_host_if.sv
// Bench for sqrt2_host_if with a behavioural sqrt2 core model on IO_DATA.
module tb_sqrt2_host_if;

    localparam int GAP = 3;
    localparam int TMO = 64;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [15:0] IN_DATA = 16'd0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [15:0] OUT_DATA;
    logic        OUT_NAN, OUT_PINF, OUT_NINF, OUT_TIMEOUT;
    logic        BUSY, ENABLE;
    wire  [15:0] IO_DATA;
    logic        RESULT = 1'b0;
    logic        IS_NAN = 1'b0, IS_PINF = 1'b0, IS_NINF = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    sqrt2_host_if #(.TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .OUT_NAN(OUT_NAN), .OUT_PINF(OUT_PINF), .OUT_NINF(OUT_NINF),
        .OUT_TIMEOUT(OUT_TIMEOUT), .BUSY(BUSY), .ENABLE(ENABLE),
        .IO_DATA(IO_DATA), .RESULT(RESULT),
        .IS_NAN(IS_NAN), .IS_PINF(IS_PINF), .IS_NINF(IS_NINF)
    );

    always #5 CLK = ~CLK;

    // Hand-computed core results: {nan, pinf, ninf, data}.
    function automatic logic [18:0] core_ref(input logic [15:0] op);
        case (op)
            16'h4400: return {3'b000, 16'h4000};   // sqrt(4)   = 2
            16'h3C00: return {3'b000, 16'h3C00};   // sqrt(1)   = 1
            16'h7C00: return {3'b010, 16'h7C00};   // sqrt(+inf)= +inf
            16'hC000: return {3'b100, 16'h7E00};   // sqrt(-2)  = NaN
            16'hFC00: return {3'b101, 16'h7E00};   // sqrt(-inf): NaN with NINF
            default:  return {3'b000, 16'h0000};
        endcase
    endfunction

    // Core model: latches the operand at the end of LOAD, presents the result
    // core_lat cycles later, and goes quiet whenever ENABLE is low.
    logic        core_drive = 1'b0;
    logic [15:0] core_data = 16'd0;
    logic [18:0] core_pend = 19'd0;
    logic [1:0]  phase = 2'd0;
    int          cnt = 0;
    int          core_lat = 1;
    bit          core_mute = 1'b0;

    assign IO_DATA = core_drive ? core_data : 16'hzzzz;

    always @(posedge CLK) begin
        if (!ENABLE) begin
            core_drive <= 1'b0;
            RESULT     <= 1'b0;
            {IS_NAN, IS_PINF, IS_NINF} <= 3'b000;
            phase      <= 2'd0;
        end else begin
            case (phase)
                2'd0: begin
                    core_pend <= core_ref(IO_DATA);
                    if (core_lat == 0 && !core_mute) begin
                        {IS_NAN, IS_PINF, IS_NINF, core_data} <= core_ref(IO_DATA);
                        core_drive <= 1'b1;
                        RESULT     <= 1'b1;
                        phase      <= 2'd2;
                    end else begin
                        cnt   <= core_lat;
                        phase <= 2'd1;
                    end
                end
                2'd1: begin
                    if (!core_mute) begin
                        if (cnt <= 1) begin
                            {IS_NAN, IS_PINF, IS_NINF, core_data} <= core_pend;
                            core_drive <= 1'b1;
                            RESULT     <= 1'b1;
                            phase      <= 2'd2;
                        end else begin
                            cnt <= cnt - 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation: handshake, wait, check result, hold, consume, gap.
    task automatic do_op(input logic [15:0] op, input int lat, input int hold);
        logic [18:0] exp;
        int n;
        int low;
        exp = core_ref(op);
        core_lat = lat;
        n = 0;
        while (!IN_READY && n < 50) begin @(posedge CLK); #1; n++; end
        check_eq("in_ready", IN_READY, 1);
        IN_DATA  = op;
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        check_eq("load_en", ENABLE, 1);
        check_eq("load_bus", IO_DATA, op);
        check_eq("load_rdy", IN_READY, 0);
        n = 0;
        do begin
            @(posedge CLK); #1; n++;
            if (!OUT_VALID) check_eq("wait_en", ENABLE, 1);
        end while (!OUT_VALID && n < 200);
        check_eq("latency", n, lat + 2);
        check_eq("data", OUT_DATA, exp[15:0]);
        check_eq("nan", OUT_NAN, exp[18]);
        check_eq("pinf", OUT_PINF, exp[17]);
        check_eq("ninf", OUT_NINF, exp[16]);
        check_eq("timeout", OUT_TIMEOUT, 0);
        check_eq("hold_en", ENABLE, 0);
        low = 1;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1; low++;
            check_eq("hold_valid", OUT_VALID, 1);
            check_eq("hold_data", OUT_DATA, exp[15:0]);
            check_eq("hold_en", ENABLE, 0);
            check_eq("hold_rdy", IN_READY, 0);
        end
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        check_eq("consumed", OUT_VALID, 0);
        check_eq("kept_data", OUT_DATA, exp[15:0]);
        n = 0;
        while (!IN_READY && n < 50) begin
            check_eq("gap_en", ENABLE, 0);
            low++;
            @(posedge CLK); #1; n++;
        end
        check_eq("gap_len", low, (hold + 1 >= GAP) ? hold + 1 : GAP);
        $display("op %h lat %0d hold %0d -> data %h nan %b pinf %b ninf %b", op, lat, hold,
                 OUT_DATA, OUT_NAN, OUT_PINF, OUT_NINF);
    endtask

    initial begin
        logic [15:0] ops[2];
        logic [15:0] exps[2];
        int idx, ridx, n;
        bit acc;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_en", ENABLE, 0);
        check_eq("rst_rdy", IN_READY, 0);
        check_eq("rst_valid", OUT_VALID, 0);
        check_eq("rst_data", OUT_DATA, 0);
        check_eq("rst_flags", {OUT_NAN, OUT_PINF, OUT_NINF, OUT_TIMEOUT}, 0);
        check_eq("rst_busy", BUSY, 0);
        @(negedge CLK); RST_N = 1'b1;
        @(posedge CLK); #1;
        check_eq("rel_rdy", IN_READY, 1);
        check_eq("rel_busy", BUSY, 0);

        do_op(16'h4400, 0, 0);   // minimum latency
        do_op(16'h7C00, 2, 0);   // +inf, full gap exercised
        do_op(16'hC000, 1, 10);  // NaN, output back-pressure

        // Two operands offered continuously with OUT_READY held high
        ops[0] = 16'h3C00; ops[1] = 16'h4400;
        exps[0] = 16'h3C00; exps[1] = 16'h4000;
        core_lat = 1;
        OUT_READY = 1'b1;
        idx = 0; ridx = 0;
        IN_DATA = ops[0]; IN_VALID = 1'b1;
        for (int c = 0; c < 100 && ridx < 2; c++) begin
            @(negedge CLK);
            acc = IN_VALID && IN_READY;
            if (core_drive) check_eq("bus_own", IO_DATA, core_data);
            if (OUT_VALID) begin
                check_eq("stream_data", OUT_DATA, exps[ridx]);
                $display("stream result %0d data %h", ridx, OUT_DATA);
                ridx++;
            end
            @(posedge CLK); #1;
            if (acc) begin
                idx++;
                if (idx >= 2) IN_VALID = 1'b0;
                else IN_DATA = ops[idx];
            end
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        check_eq("stream_count", ridx, 2);

        // Reset during WAIT
        core_lat = 6;
        n = 0;
        while (!IN_READY && n < 50) begin @(posedge CLK); #1; n++; end
        IN_DATA = 16'h4400; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        check_eq("pre_rst_en", ENABLE, 1);
        RST_N = 1'b0;
        #1;
        check_eq("mid_rst_en", ENABLE, 0);
        check_eq("mid_rst_busy", BUSY, 0);
        check_eq("mid_rst_valid", OUT_VALID, 0);
        check_eq("mid_rst_data", OUT_DATA, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK); RST_N = 1'b1;
        @(posedge CLK); #1;
        check_eq("post_rst_rdy", IN_READY, 1);
        check_eq("post_rst_valid", OUT_VALID, 0);
        $display("reset during WAIT: en %b rdy %b", ENABLE, IN_READY);

        do_op(16'hFC00, 3, 0);   // multiple flags pass through

`ifdef SQRT2_HOST_IF_TIMEOUT_EN
        // Core never answers: abort after TMO WAIT cycles
        core_mute = 1'b1;
        IN_DATA = 16'h4400; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (!OUT_VALID && n < 200);
        check_eq("tmo_latency", n, TMO + 1);
        check_eq("tmo_flag", OUT_TIMEOUT, 1);
        check_eq("tmo_data", OUT_DATA, 16'h7E00);
        check_eq("tmo_flags", {OUT_NAN, OUT_PINF, OUT_NINF}, 3'b100);
        $display("timeout op -> data %h timeout %b", OUT_DATA, OUT_TIMEOUT);
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        core_mute = 1'b0;
        // Result arrives on the last WAIT cycle: normal capture wins
        do_op(16'h4400, TMO - 1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sqrt2_host_if.md
Name: sqrt2_host_if

Overview:
- Upstream sequencer for the sqrt2 half-precision square-root core.
- Accepts operands on a valid/ready stream and drives the core's ENABLE and the shared bidirectional IO_DATA bus.
- Captures the result word and the IS_NAN/IS_PINF/IS_NINF flags, then presents them on a valid/ready output stream.
- Handles one operation at a time and owns bus turnaround.

Parameters:
TIMEOUT_CYCLES, 64, max WAIT cycles before abort (used only with the optional feature); 1..65535
GAP_CYCLES, 1, cycles ENABLE is held low between operations to re-arm the core; >=1

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
IN_VALID  input  1  operand valid
IN_READY  output  1  operand accepted when IN_VALID&IN_READY
IN_DATA  input  16  half-precision operand
OUT_VALID  output  1  result valid
OUT_READY  input  1  result consumed when OUT_VALID&OUT_READY
OUT_DATA  output  16  captured result word
OUT_NAN  output  1  captured IS_NAN
OUT_PINF  output  1  captured IS_PINF
OUT_NINF  output  1  captured IS_NINF
OUT_TIMEOUT  output  1  operation aborted (optional feature; tied 0 otherwise)
BUSY  output  1  high in any state except IDLE
ENABLE  output  1  to core ENABLE
IO_DATA  inout  16  shared bus to core
RESULT  input  1  from core RESULT
IS_NAN, IS_PINF, IS_NINF  input  1 each  from core

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE, ENABLE=0, IO_DATA released (Z), IN_READY=0.
  - OUT_VALID=0, OUT_DATA=0, all OUT flags=0, BUSY=0.
  - counters cleared.
- FSM states: IDLE, LOAD, WAIT, HOLD, GAP.
- IDLE:
  - IN_READY=1.
  - On IN_VALID&IN_READY at edge T: latch IN_DATA into op register; go to LOAD.
- LOAD (cycle T+1):
  - ENABLE=1; IO_DATA driven with op register for exactly this one cycle; IN_READY=0.
  - Next state WAIT.
- WAIT:
  - ENABLE=1; IO_DATA=Z (driver never drives the bus outside LOAD).
  - At the first edge with RESULT=1: capture IO_DATA, IS_NAN, IS_PINF, IS_NINF into output registers; OUT_VALID=1 from the next cycle; go to HOLD.
  - RESULT high in LOAD is ignored; only WAIT samples it.
- HOLD:
  - ENABLE=0.
  - OUT_VALID held with stable payload until OUT_VALID&OUT_READY; then OUT_VALID=0 at the next cycle and go to GAP.
  - Gap counter runs concurrently from HOLD entry.
- GAP:
  - ENABLE=0; counts so ENABLE has been low >=GAP_CYCLES total since HOLD entry.
  - Then IDLE. If already satisfied on HOLD exit, goes straight to IDLE.
- Minimum operation time: IN handshake edge T, LOAD T+1, earliest capture at the end of the first WAIT cycle, OUT_VALID asserted the cycle after capture.
- Back-to-back: a new operand is accepted only in IDLE; no pipelining across operations.
- Output payload registers change only at capture; they keep the last value after consumption.
- Reset mid-operation (any state):
  - Immediate ENABLE=0 and bus release (asynchronous).
  - Pending result discarded; OUT_VALID=0.
- Simultaneous RESULT=1 and timeout expiry in WAIT: RESULT wins (normal capture, OUT_TIMEOUT=0).
- Multiple flags high at capture are passed through unmodified.

Optional Feature:
- Macro: SQRT2_HOST_IF_TIMEOUT_EN.
- Defined:
  - 16-bit wait counter clears on LOAD and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with RESULT still 0, go to HOLD with OUT_TIMEOUT=1, OUT_DATA=0x7E00, OUT_NAN=1, other flags 0.
  - ENABLE drops as in normal HOLD.
  - OUT_TIMEOUT clears at the next capture.
- Not defined: no counter; OUT_TIMEOUT constant 0; WAIT is unbounded.

Test Plan:
- Reset then IN_DATA=0x4400 (4.0) with core model -> IO_DATA=0x4400 only in the LOAD cycle, ENABLE high LOAD..capture, OUT_DATA=0x4000, flags 0.
- IN_DATA=0x7C00 (+inf) -> OUT_PINF=1, OUT_NAN=0, OUT_NINF=0; ENABLE low >=GAP_CYCLES before IN_READY returns.
- IN_DATA=0xC000 (-2.0) -> OUT_NAN=1; OUT_READY held 0 for 10 cycles -> OUT_VALID and payload stable all 10 cycles, ENABLE=0, IN_READY=0.
- Two operands 0x3C00 then 0x4400 offered continuously -> results 0x3C00 then 0x4000 in order; no cycle where driver and core both drive IO_DATA.
- Macro defined, TIMEOUT_CYCLES=64, RESULT forced 0 -> OUT_TIMEOUT=1, OUT_DATA=0x7E00 after 64 WAIT cycles; RESULT=1 on cycle 64 -> normal capture.
- RST_N pulsed low during WAIT -> ENABLE=0 and IO_DATA=Z in the same cycle, OUT_VALID=0, IN_READY=1 after release.
